// File: rtl/sprite_pkg.sv
// Shared constants and sprite table entry type for the sprite layer scheduler.
package sprite_pkg;

  localparam int SPR_W_DEF    = 16;
  localparam int SPR_H_DEF    = 16;
  localparam int CW_DEF       = 11;
  localparam int SPR_PIPE_LAT = 3;

  typedef struct packed {
    logic              en;
    logic [CW_DEF-1:0] x;
    logic [CW_DEF-1:0] y;
  } spr_entry_t;

endpackage

// File: rtl/spr_prio_enc.sv
// Priority encoder over the per-sprite hit vector; the lowest set index wins.
module spr_prio_enc
  import sprite_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  hit,
  output logic          any,
  output logic [IW-1:0] idx
);

  always_comb begin
    any = |hit;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (hit[i]) idx = IW'(i);
    end
  end

endmodule

// File: rtl/sprite_layer_scheduler.sv
// Shares one 16x16 sprite ROM between N_SPR sprite instances and composites over background.
// Optional sticky overlap flag on port 'collision' when SPRITE_COLLISION_EN is defined.
module sprite_layer_scheduler
  import sprite_pkg::*;
#(
  parameter int N_SPR = 4,
  parameter int SPR_W = SPR_W_DEF,
  parameter int SPR_H = SPR_H_DEF,
  parameter int CW    = CW_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     frame_start,
  input  logic                     pix_valid,
  input  logic [CW-1:0]            pix_x,
  input  logic [CW-1:0]            pix_y,
  input  logic [7:0]               bg_r,
  input  logic [7:0]               bg_g,
  input  logic [7:0]               bg_b,
  input  logic                     cfg_wr,
  input  logic [$clog2(N_SPR)-1:0] cfg_idx,
  input  logic [CW-1:0]            cfg_x,
  input  logic [CW-1:0]            cfg_y,
  input  logic                     cfg_en,
  output logic [CW-1:0]            rom_ix,
  output logic [CW-1:0]            rom_iy,
  input  logic [7:0]               rom_r,
  input  logic [7:0]               rom_g,
  input  logic [7:0]               rom_b,
  input  logic                     rom_mask,
  output logic                     out_valid,
  output logic [7:0]               out_r,
  output logic [7:0]               out_g,
  output logic [7:0]               out_b,
  output logic                     out_hit,
`ifdef SPRITE_COLLISION_EN
  output logic                     collision,
`endif
  output logic [$clog2(N_SPR)-1:0] out_idx
);

  localparam int IW = $clog2(N_SPR);

  spr_entry_t shadow [N_SPR];
  spr_entry_t active [N_SPR];

  // A commit copies the pre-write shadow, so a coincident cfg_wr lands next frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_SPR; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_SPR; i++) begin
        if (frame_start) active[i] <= shadow[i];
        if (cfg_wr && cfg_idx == IW'(i)) shadow[i] <= '{en: cfg_en, x: cfg_x, y: cfg_y};
      end
    end
  end

  logic [CW:0]       px_e, py_e;
  logic [N_SPR-1:0]  hit;
  logic              any_hit;
  logic [IW-1:0]     win_idx;
  logic [CW-1:0]     lx_s0, ly_s0;

  assign px_e = {1'b0, pix_x};
  assign py_e = {1'b0, pix_y};

  // Bounds are extended by one bit so a sprite at the coordinate edge never wraps to 0.
  always_comb begin
    hit = '0;
    for (int i = 0; i < N_SPR; i++) begin
      hit[i] = active[i].en
            && px_e >= {1'b0, active[i].x} && px_e < {1'b0, active[i].x} + (CW+1)'(SPR_W)
            && py_e >= {1'b0, active[i].y} && py_e < {1'b0, active[i].y} + (CW+1)'(SPR_H);
    end
  end

  spr_prio_enc #(.N(N_SPR), .IW(IW)) u_prio (
    .hit (hit),
    .any (any_hit),
    .idx (win_idx)
  );

  assign lx_s0 = pix_x - active[win_idx].x;
  assign ly_s0 = pix_y - active[win_idx].y;

  logic          vld_p1, win_p1, vld_p2, win_p2;
  logic [IW-1:0] idx_p1, idx_p2;
  logic [CW-1:0] lx_p1, ly_p1, lx_p2;
  logic [23:0]   bg_p1, bg_p2;
  logic          opaque_p2;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      win_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      win_p2 <= 1'b0;
    end else begin
      vld_p1 <= pix_valid;
      win_p1 <= any_hit;
      vld_p2 <= vld_p1;
      win_p2 <= win_p1;
    end
  end

  // S1: winner and local coordinates; the ROM latches its row from rom_iy at the next edge
  always_ff @(posedge clk) begin
    idx_p1 <= win_idx;
    lx_p1  <= lx_s0;
    ly_p1  <= ly_s0;
    bg_p1  <= {bg_r, bg_g, bg_b};
  end

  assign rom_iy = (vld_p1 && win_p1) ? ly_p1 : '0;

  // S2: column drives the ROM combinationally; ROM colour/mask are consumed here
  always_ff @(posedge clk) begin
    idx_p2 <= idx_p1;
    lx_p2  <= lx_p1;
    bg_p2  <= bg_p1;
  end

  assign rom_ix    = (vld_p2 && win_p2) ? lx_p2 : '0;
  assign opaque_p2 = win_p2 && rom_mask;

  // S3: output register; bubbles leave the previous pixel on out_*
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_hit   <= 1'b0;
      out_idx   <= '0;
      out_r     <= '0;
      out_g     <= '0;
      out_b     <= '0;
    end else begin
      out_valid <= vld_p2;
      if (vld_p2) begin
        out_hit                <= opaque_p2;
        out_idx                <= idx_p2;
        {out_r, out_g, out_b}  <= opaque_p2 ? {rom_r, rom_g, rom_b} : bg_p2;
      end
    end
  end

`ifdef SPRITE_COLLISION_EN
  logic multi_hit;
  assign multi_hit = |(hit & (hit - N_SPR'(1)));

  // A frame_start clear loses to an overlapping pixel in the same cycle.
  always_ff @(posedge clk) begin
    if (rst)                          collision <= 1'b0;
    else if (pix_valid && multi_hit)  collision <= 1'b1;
    else if (frame_start)             collision <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_sprite_layer_scheduler.sv
// Directed bench for sprite_layer_scheduler with a behavioural 16x16 ROM (registered row, combinational column).
module tb_sprite_layer_scheduler;

  localparam int CW = 11;

  logic          clk, rst, frame_start, pix_valid;
  logic [CW-1:0] pix_x, pix_y;
  logic [7:0]    bg_r, bg_g, bg_b;
  logic          cfg_wr, cfg_en;
  logic [1:0]    cfg_idx;
  logic [CW-1:0] cfg_x, cfg_y;
  logic [CW-1:0] rom_ix, rom_iy;
  logic [7:0]    rom_r, rom_g, rom_b;
  logic          rom_mask;
  logic          out_valid, out_hit;
  logic [7:0]    out_r, out_g, out_b;
  logic [1:0]    out_idx;
`ifdef SPRITE_COLLISION_EN
  logic          collision;
`endif

  logic       mask_ctl;
  logic [3:0] rom_row_q;
  int total = 0;
  int bad   = 0;

  sprite_layer_scheduler dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .pix_valid(pix_valid),
    .pix_x(pix_x), .pix_y(pix_y), .bg_r(bg_r), .bg_g(bg_g), .bg_b(bg_b),
    .cfg_wr(cfg_wr), .cfg_idx(cfg_idx), .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_en(cfg_en),
    .rom_ix(rom_ix), .rom_iy(rom_iy), .rom_r(rom_r), .rom_g(rom_g), .rom_b(rom_b),
    .rom_mask(rom_mask), .out_valid(out_valid), .out_r(out_r), .out_g(out_g), .out_b(out_b),
    .out_hit(out_hit),
`ifdef SPRITE_COLLISION_EN
    .collision(collision),
`endif
    .out_idx(out_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM: row registered from rom_iy, column combinational on rom_ix
  always @(posedge clk) rom_row_q <= rom_iy[3:0];
  assign rom_r    = {rom_row_q, rom_ix[3:0]};
  assign rom_g    = 8'hC3;
  assign rom_b    = {rom_ix[3:0], rom_row_q};
  assign rom_mask = mask_ctl;

  // Layout: {out_valid one cycle early, out_valid, out_hit, out_idx (0 unless hit), r, g, b}
  function automatic logic [28:0] e_hit(input logic [1:0] idx, input logic [3:0] lx, input logic [3:0] ly);
    return {1'b0, 1'b1, 1'b1, idx, ly, lx, 8'hC3, lx, ly};
  endfunction

  function automatic logic [28:0] e_bg(input logic [23:0] bg);
    return {1'b0, 1'b1, 1'b0, 2'b00, bg};
  endfunction

  task automatic cfg(input logic [1:0] idx, input logic [CW-1:0] x, input logic [CW-1:0] y, input logic en);
    cfg_idx = idx; cfg_x = x; cfg_y = y; cfg_en = en; cfg_wr = 1'b1;
    @(negedge clk);
    cfg_wr = 1'b0;
  endtask

  task automatic commit();
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic run_pix(input logic [CW-1:0] x, input logic [CW-1:0] y, input logic [23:0] bg,
                         input logic fs, output logic [CW-1:0] iy1, output logic [CW-1:0] ix2,
                         output logic [28:0] res);
    logic v2;
    pix_x = x; pix_y = y; {bg_r, bg_g, bg_b} = bg; pix_valid = 1'b1; frame_start = fs;
    @(negedge clk);
    pix_valid = 1'b0; frame_start = 1'b0;
    iy1 = rom_iy;
    @(negedge clk);
    ix2 = rom_ix;
    v2  = out_valid;
    @(negedge clk);
    res = {v2, out_valid, out_hit, (out_hit ? out_idx : 2'b00), out_r, out_g, out_b};
  endtask

  task automatic test_reset();
    logic [CW-1:0] iy, ix;
    logic [28:0]   res;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({out_valid, out_hit, out_idx, out_r, out_g, out_b, rom_ix, rom_iy} !== '0) begin
      bad++; $display("FAIL reset_outputs got=%h want=0", {out_valid, out_hit, out_idx, out_r, out_g, out_b, rom_ix, rom_iy});
    end
    rst = 1'b0;
    @(negedge clk);
    run_pix(11'd7, 11'd9, 24'h112233, 1'b0, iy, ix, res);
    total++; if (res !== e_bg(24'h112233)) begin bad++; $display("FAIL reset_bg_pix got=%h want=%h", res, e_bg(24'h112233)); end
    total++; if ({iy, ix} !== 22'd0) begin bad++; $display("FAIL reset_rom_addr got=%h want=0", {iy, ix}); end
    run_pix(11'd2047, 11'd2047, 24'hA5A55A, 1'b0, iy, ix, res);
    total++; if (res !== e_bg(24'hA5A55A)) begin bad++; $display("FAIL reset_corner_pix got=%h want=%h", res, e_bg(24'hA5A55A)); end
    @(negedge clk);
    total++;
    if ({out_valid, out_r, out_g, out_b} !== {1'b0, 24'hA5A55A}) begin
      bad++; $display("FAIL bubble_hold got=%h want=%h", {out_valid, out_r, out_g, out_b}, {1'b0, 24'hA5A55A});
    end
  endtask

  task automatic test_basic_hit();
    logic [CW-1:0] iy, ix;
    logic [28:0]   res;
    mask_ctl = 1'b1;
    cfg(2'd0, 11'd100, 11'd50, 1'b1);
    run_pix(11'd100, 11'd50, 24'h0A0B0C, 1'b0, iy, ix, res);
    total++; if (res !== e_bg(24'h0A0B0C)) begin bad++; $display("FAIL uncommitted got=%h want=%h", res, e_bg(24'h0A0B0C)); end
    commit();
    run_pix(11'd100, 11'd50, 24'h010203, 1'b0, iy, ix, res);
    total++; if (res !== e_hit(2'd0, 4'd0, 4'd0)) begin bad++; $display("FAIL basic_origin got=%h want=%h", res, e_hit(2'd0, 4'd0, 4'd0)); end
    run_pix(11'd103, 11'd57, 24'h010203, 1'b0, iy, ix, res);
    total++; if (res !== e_hit(2'd0, 4'd3, 4'd7)) begin bad++; $display("FAIL basic_inner got=%h want=%h", res, e_hit(2'd0, 4'd3, 4'd7)); end
    total++; if ({iy, ix} !== {11'd7, 11'd3}) begin bad++; $display("FAIL basic_rom_addr got=%h want=%h", {iy, ix}, {11'd7, 11'd3}); end
    run_pix(11'd115, 11'd65, 24'h010203, 1'b0, iy, ix, res);
    total++; if (res !== e_hit(2'd0, 4'd15, 4'd15)) begin bad++; $display("FAIL basic_far_corner got=%h want=%h", res, e_hit(2'd0, 4'd15, 4'd15)); end
    run_pix(11'd116, 11'd50, 24'h445566, 1'b0, iy, ix, res);
    total++; if (res !== e_bg(24'h445566)) begin bad++; $display("FAIL basic_right_edge got=%h want=%h", res, e_bg(24'h445566)); end
    total++; if ({iy, ix} !== 22'd0) begin bad++; $display("FAIL miss_rom_addr got=%h want=0", {iy, ix}); end
    run_pix(11'd99, 11'd50, 24'h778899, 1'b0, iy, ix, res);
    total++; if (res !== e_bg(24'h778899)) begin bad++; $display("FAIL basic_left_edge got=%h want=%h", res, e_bg(24'h778899)); end
    run_pix(11'd100, 11'd66, 24'h123456, 1'b0, iy, ix, res);
    total++; if (res !== e_bg(24'h123456)) begin bad++; $display("FAIL basic_bottom_edge got=%h want=%h", res, e_bg(24'h123456)); end
  endtask

  task automatic test_priority();
    logic [CW-1:0] iy, ix;
    logic [28:0]   res;
    cfg(2'd0, 11'd10, 11'd10, 1'b1);
    cfg(2'd1, 11'd10, 11'd10, 1'b1);
    commit();
    run_pix(11'd12, 11'd12, 24'h202020, 1'b0, iy, ix, res);
    total++; if (res !== e_hit(2'd0, 4'd2, 4'd2)) begin bad++; $display("FAIL prio_overlap got=%h want=%h", res, e_hit(2'd0, 4'd2, 4'd2)); end
    mask_ctl = 1'b0;
    run_pix(11'd12, 11'd12, 24'h303132, 1'b0, iy, ix, res);
    total++; if (res !== e_bg(24'h303132)) begin bad++; $display("FAIL prio_transparent got=%h want=%h", res, e_bg(24'h303132)); end
    mask_ctl = 1'b1;
    cfg(2'd0, 11'd10, 11'd10, 1'b0);
    commit();
    run_pix(11'd13, 11'd14, 24'h202020, 1'b0, iy, ix, res);
    total++; if (res !== e_hit(2'd1, 4'd3, 4'd4)) begin bad++; $display("FAIL prio_entry1 got=%h want=%h", res, e_hit(2'd1, 4'd3, 4'd4)); end
    cfg(2'd2, 11'd301, 11'd301, 1'b1);
    cfg(2'd3, 11'd300, 11'd300, 1'b1);
    commit();
    run_pix(11'd305, 11'd306, 24'h202020, 1'b0, iy, ix, res);
    total++; if (res !== e_hit(2'd2, 4'd4, 4'd5)) begin bad++; $display("FAIL prio_entry2 got=%h want=%h", res, e_hit(2'd2, 4'd4, 4'd5)); end
    run_pix(11'd300, 11'd300, 24'h202020, 1'b0, iy, ix, res);
    total++; if (res !== e_hit(2'd3, 4'd0, 4'd0)) begin bad++; $display("FAIL prio_entry3 got=%h want=%h", res, e_hit(2'd3, 4'd0, 4'd0)); end
  endtask

  task automatic test_commit_race();
    logic [CW-1:0] iy, ix;
    logic [28:0]   res;
    cfg(2'd0, 11'd100, 11'd50, 1'b1);
    cfg(2'd1, 11'd0, 11'd0, 1'b0);
    cfg(2'd2, 11'd0, 11'd0, 1'b0);
    cfg(2'd3, 11'd0, 11'd0, 1'b0);
    commit();
    cfg_idx = 2'd0; cfg_x = 11'd200; cfg_y = 11'd50; cfg_en = 1'b1; cfg_wr = 1'b1; frame_start = 1'b1;
    @(negedge clk);
    cfg_wr = 1'b0; frame_start = 1'b0;
    run_pix(11'd100, 11'd50, 24'h0F0F0F, 1'b0, iy, ix, res);
    total++; if (res !== e_hit(2'd0, 4'd0, 4'd0)) begin bad++; $display("FAIL race_old_pos got=%h want=%h", res, e_hit(2'd0, 4'd0, 4'd0)); end
    run_pix(11'd200, 11'd50, 24'h0F0F0F, 1'b0, iy, ix, res);
    total++; if (res !== e_bg(24'h0F0F0F)) begin bad++; $display("FAIL race_new_early got=%h want=%h", res, e_bg(24'h0F0F0F)); end
    run_pix(11'd105, 11'd52, 24'h0F0F0F, 1'b1, iy, ix, res);
    total++; if (res !== e_hit(2'd0, 4'd5, 4'd2)) begin bad++; $display("FAIL fs_pixel_old_table got=%h want=%h", res, e_hit(2'd0, 4'd5, 4'd2)); end
    run_pix(11'd200, 11'd50, 24'h0F0F0F, 1'b0, iy, ix, res);
    total++; if (res !== e_hit(2'd0, 4'd0, 4'd0)) begin bad++; $display("FAIL race_new_pos got=%h want=%h", res, e_hit(2'd0, 4'd0, 4'd0)); end
    run_pix(11'd100, 11'd50, 24'h0E0E0E, 1'b0, iy, ix, res);
    total++; if (res !== e_bg(24'h0E0E0E)) begin bad++; $display("FAIL race_old_gone got=%h want=%h", res, e_bg(24'h0E0E0E)); end
  endtask

  task automatic test_wrap();
    logic [CW-1:0] iy, ix;
    logic [28:0]   res;
    cfg(2'd0, 11'd2040, 11'd0, 1'b1);
    cfg(2'd1, 11'd500, 11'd2040, 1'b1);
    commit();
    run_pix(11'd3, 11'd0, 24'h606060, 1'b0, iy, ix, res);
    total++; if (res !== e_bg(24'h606060)) begin bad++; $display("FAIL wrap_x got=%h want=%h", res, e_bg(24'h606060)); end
    run_pix(11'd500, 11'd3, 24'h616161, 1'b0, iy, ix, res);
    total++; if (res !== e_bg(24'h616161)) begin bad++; $display("FAIL wrap_y got=%h want=%h", res, e_bg(24'h616161)); end
    run_pix(11'd2047, 11'd5, 24'h606060, 1'b0, iy, ix, res);
    total++; if (res !== e_hit(2'd0, 4'd7, 4'd5)) begin bad++; $display("FAIL edge_hit got=%h want=%h", res, e_hit(2'd0, 4'd7, 4'd5)); end
    run_pix(11'd2040, 11'd16, 24'h626262, 1'b0, iy, ix, res);
    total++; if (res !== e_bg(24'h626262)) begin bad++; $display("FAIL edge_below got=%h want=%h", res, e_bg(24'h626262)); end
  endtask

  task automatic test_back_to_back();
    logic [CW-1:0] xs [4];
    logic [CW-1:0] ys [4];
    logic [23:0]   bgs [4];
    logic [28:0]   exp [4];
    logic [28:0]   got;
    xs[0] = 11'd2040; ys[0] = 11'd1;    bgs[0] = 24'h111111; exp[0] = e_hit(2'd0, 4'd0, 4'd1);
    xs[1] = 11'd3;    ys[1] = 11'd1;    bgs[1] = 24'h222222; exp[1] = e_bg(24'h222222);
    xs[2] = 11'd2043; ys[2] = 11'd2;    bgs[2] = 24'h333333; exp[2] = e_hit(2'd0, 4'd3, 4'd2);
    xs[3] = 11'd500;  ys[3] = 11'd2041; bgs[3] = 24'h444444; exp[3] = e_hit(2'd1, 4'd0, 4'd1);
    for (int k = 0; k < 7; k++) begin
      if (k < 4) begin
        pix_x = xs[k]; pix_y = ys[k]; {bg_r, bg_g, bg_b} = bgs[k]; pix_valid = 1'b1;
      end else begin
        pix_valid = 1'b0;
      end
      @(negedge clk);
      got = {1'b0, out_valid, out_hit, (out_hit ? out_idx : 2'b00), out_r, out_g, out_b};
      if (k >= 2 && k <= 5) begin
        total++; if (got !== exp[k-2]) begin bad++; $display("FAIL b2b_pix%0d got=%h want=%h", k - 2, got, exp[k-2]); end
      end else if (k == 6) begin
        total++; if (got !== {exp[3][28], 1'b0, exp[3][26:0]}) begin bad++; $display("FAIL b2b_tail got=%h want=%h", got, {exp[3][28], 1'b0, exp[3][26:0]}); end
      end else begin
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_lead%0d got=%b want=0", k, out_valid); end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [CW-1:0] iy, ix;
    logic [28:0]   res;
    cfg(2'd0, 11'd100, 11'd50, 1'b1);
    commit();
    pix_x = 11'd100; pix_y = 11'd50; {bg_r, bg_g, bg_b} = 24'h505050; pix_valid = 1'b1;
    @(negedge clk);
    pix_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if ({out_valid, out_hit, out_r, out_g, out_b, rom_ix, rom_iy} !== '0) begin
      bad++; $display("FAIL midrst_outputs got=%h want=0", {out_valid, out_hit, out_r, out_g, out_b, rom_ix, rom_iy});
    end
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_flush got=%b want=0", out_valid); end
    run_pix(11'd100, 11'd50, 24'h515151, 1'b0, iy, ix, res);
    total++; if (res !== e_bg(24'h515151)) begin bad++; $display("FAIL midrst_active_clear got=%h want=%h", res, e_bg(24'h515151)); end
    commit();
    run_pix(11'd100, 11'd50, 24'h525252, 1'b0, iy, ix, res);
    total++; if (res !== e_bg(24'h525252)) begin bad++; $display("FAIL midrst_shadow_clear got=%h want=%h", res, e_bg(24'h525252)); end
  endtask

`ifdef SPRITE_COLLISION_EN
  task automatic test_collision();
    logic [CW-1:0] iy, ix;
    logic [28:0]   res;
    cfg(2'd0, 11'd20, 11'd20, 1'b1);
    cfg(2'd1, 11'd10, 11'd10, 1'b1);
    commit();
    run_pix(11'd5, 11'd5, 24'h0, 1'b0, iy, ix, res);
    total++; if (collision !== 1'b0) begin bad++; $display("FAIL coll_clear got=%b want=0", collision); end
    run_pix(11'd20, 11'd20, 24'h0, 1'b0, iy, ix, res);
    total++; if (collision !== 1'b1) begin bad++; $display("FAIL coll_set got=%b want=1", collision); end
    commit();
    total++; if (collision !== 1'b0) begin bad++; $display("FAIL coll_frame_clear got=%b want=0", collision); end
    run_pix(11'd21, 11'd21, 24'h0, 1'b1, iy, ix, res);
    total++; if (collision !== 1'b1) begin bad++; $display("FAIL coll_fs_same_cycle got=%b want=1", collision); end
  endtask
`endif

  initial begin
    rst = 1'b1; frame_start = 1'b0; pix_valid = 1'b0; pix_x = '0; pix_y = '0;
    bg_r = '0; bg_g = '0; bg_b = '0; cfg_wr = 1'b0; cfg_idx = '0; cfg_x = '0; cfg_y = '0;
    cfg_en = 1'b0; mask_ctl = 1'b1;
    test_reset();
    test_basic_hit();
    test_priority();
    test_commit_race();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
`ifdef SPRITE_COLLISION_EN
    test_collision();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
